// File: rtl/saturn_control_unit.sv
// saturn_control_unit: instruction fetch/decode core of the Saturn CPU.
// Fills the bus program list with the PC-load sequence after reset, then
// accepts one nibble per 0010 phase and decodes P=n, LC, ST=0/1 and CLRHST.
// Optional macro SATURN_CTRL_TRACE_EN adds a simulation-only decode trace.
module saturn_control_unit #(
    parameter int          PROG_DEPTH = 32,
    parameter logic [19:0] RESET_PC   = 20'h00000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_clk_en,
    input  logic [3:0]  i_phases,
    input  logic [1:0]  i_phase,
    input  logic [31:0] i_cycle_ctr,
    input  logic        i_bus_busy,
    output logic [4:0]  o_program_address,
    input  logic [4:0]  i_program_address,
    output logic [4:0]  o_program_data,
    output logic        o_no_read,
    input  logic [3:0]  i_nibble,
    output logic        o_error,
    output logic [19:0] o_current_pc,
    output logic [3:0]  o_reg_hst,
    output logic [15:0] o_reg_st,
    output logic [3:0]  o_reg_p,
    input  logic [4:0]  i_dbg_register,
    input  logic [3:0]  i_dbg_reg_ptr,
    output logic [3:0]  o_dbg_reg_nibble,
    output logic [4:0]  o_alu_reg_dest,
    output logic [4:0]  o_alu_reg_src_1,
    output logic [4:0]  o_alu_reg_src_2,
    output logic [3:0]  o_alu_imm_value,
    output logic [4:0]  o_alu_opcode,
    output logic [3:0]  o_instr_type,
    output logic        o_instr_decoded
);
    typedef enum logic {S_INIT, S_RUN} top_e;
    typedef enum logic [2:0] {D_IDLE, D_OP2, D_LC_DATA, D_ST_N, D_HST_N} dec_e;

    top_e             top_q, top_d;
    dec_e             dec_q, dec_d;
    logic [4:0]       wp_q, wp_d;
    logic [19:0]      pc_q, pc_d, cpc_q, cpc_d;
    logic [3:0]       p_q, p_d, hst_q, hst_d;
    logic [15:0]      st_q, st_d;
    logic [15:0][3:0] c_q, c_d;          // A, B and D are never written by this subset
    logic             err_q, err_d;
    logic [3:0]       op1_q, op1_d, cnt_q, cnt_d, lcp_q, lcp_d;
    logic             stv_q, stv_d, pend_q, pend_d, pulse_q, pulse_d;
    logic [3:0]       type_q, type_d, imm_q, imm_d;
    logic [4:0]       dest_q, dest_d, aluop_q, aluop_d;
    logic [4:0]       prog_q [PROG_DEPTH];
    logic             wr_en, accept;
    logic [4:0]       wr_data;
    logic             unused_trace;

    assign unused_trace = ^{i_phase, i_cycle_ctr};
    assign accept = (top_q == S_RUN) && i_clk_en && (i_phases == 4'b0010)
                    && !i_bus_busy && !err_q;

    // Next-state logic: init program fill, nibble decode, decode pulse.
    always_comb begin
        top_d = top_q;   dec_d = dec_q;   wp_d = wp_q;     pc_d = pc_q;
        cpc_d = cpc_q;   p_d = p_q;       hst_d = hst_q;   st_d = st_q;
        c_d = c_q;       err_d = err_q;   op1_d = op1_q;   cnt_d = cnt_q;
        lcp_d = lcp_q;   stv_d = stv_q;   pend_d = pend_q; pulse_d = pulse_q;
        type_d = type_q; imm_d = imm_q;   dest_d = dest_q; aluop_d = aluop_q;
        wr_en = 1'b0;
        case (wp_q)
            5'd1:    wr_data = {1'b0, RESET_PC[3:0]};
            5'd2:    wr_data = {1'b0, RESET_PC[7:4]};
            5'd3:    wr_data = {1'b0, RESET_PC[11:8]};
            5'd4:    wr_data = {1'b0, RESET_PC[15:12]};
            5'd5:    wr_data = {1'b0, RESET_PC[19:16]};
            default: wr_data = 5'h14;    // CMD LOAD_PC
        endcase
        if (i_clk_en) begin
            // pulse lands on the 0100 phase following the final nibble
            pulse_d = pend_q && (i_phases == 4'b0100);
            if (i_phases == 4'b0100) pend_d = 1'b0;
        end
        if (top_q == S_INIT && i_clk_en) begin
            wr_en = 1'b1;
            wp_d  = wp_q + 5'd1;
            if (wp_q == 5'd5) top_d = S_RUN;
        end
        if (accept) begin
            pc_d = pc_q + 20'd1;
            case (dec_q)
                D_IDLE: begin
                    cpc_d = pc_q;
                    op1_d = i_nibble;
                    if (i_nibble == 4'h2 || i_nibble == 4'h3 || i_nibble == 4'h8) dec_d = D_OP2;
                    else err_d = 1'b1;
                end
                D_OP2: begin
                    case (op1_q)
                        4'h2: begin
                            p_d = i_nibble; type_d = 4'd1; dest_d = 5'd16;
                            imm_d = i_nibble; aluop_d = 5'd1; pend_d = 1'b1; dec_d = D_IDLE;
                        end
                        4'h3: begin
                            cnt_d = i_nibble; lcp_d = p_q; dec_d = D_LC_DATA;
                        end
                        default: begin
                            case (i_nibble)
                                4'h4:    begin stv_d = 1'b0; dec_d = D_ST_N; end
                                4'h5:    begin stv_d = 1'b1; dec_d = D_ST_N; end
                                4'h2:    dec_d = D_HST_N;
                                default: err_d = 1'b1;
                            endcase
                        end
                    endcase
                end
                D_LC_DATA: begin
                    c_d[lcp_q] = i_nibble;
                    lcp_d = lcp_q + 4'd1;           // nibble index wraps mod 16
                    type_d = 4'd2; dest_d = 5'd2; imm_d = i_nibble; aluop_d = 5'd1;
                    if (cnt_q == 4'd0) begin
                        pend_d = 1'b1; dec_d = D_IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                D_ST_N: begin
                    st_d[i_nibble] = stv_q;
                    type_d = 4'd3; dest_d = 5'd17; imm_d = i_nibble;
                    aluop_d = stv_q ? 5'd3 : 5'd2; pend_d = 1'b1; dec_d = D_IDLE;
                end
                D_HST_N: begin
                    hst_d = hst_q & ~i_nibble;
                    type_d = 4'd4; dest_d = 5'd18; imm_d = i_nibble;
                    aluop_d = 5'd2; pend_d = 1'b1; dec_d = D_IDLE;
                end
                default: dec_d = D_IDLE;
            endcase
        end
    end

    // State registers, async active-low reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            top_q <= S_INIT;  dec_q <= D_IDLE;  wp_q <= 5'd0;    pc_q <= RESET_PC;
            cpc_q <= 20'd0;   p_q <= 4'd0;      hst_q <= 4'd0;   st_q <= 16'd0;
            c_q <= '0;        err_q <= 1'b0;    op1_q <= 4'd0;   cnt_q <= 4'd0;
            lcp_q <= 4'd0;    stv_q <= 1'b0;    pend_q <= 1'b0;  pulse_q <= 1'b0;
            type_q <= 4'd0;   imm_q <= 4'd0;    dest_q <= 5'd0;  aluop_q <= 5'd0;
        end else begin
            top_q <= top_d;   dec_q <= dec_d;   wp_q <= wp_d;    pc_q <= pc_d;
            cpc_q <= cpc_d;   p_q <= p_d;       hst_q <= hst_d;  st_q <= st_d;
            c_q <= c_d;       err_q <= err_d;   op1_q <= op1_d;  cnt_q <= cnt_d;
            lcp_q <= lcp_d;   stv_q <= stv_d;   pend_q <= pend_d; pulse_q <= pulse_d;
            type_q <= type_d; imm_q <= imm_d;   dest_q <= dest_d; aluop_q <= aluop_d;
        end
    end

    // Program list storage; only written while filling the init sequence.
    always_ff @(posedge i_clk) begin
        if (wr_en) prog_q[wp_q] <= wr_data;
    end

    // Debugger nibble view; unknown register codes read as zero.
    always_comb begin
        o_dbg_reg_nibble = 4'h0;
        case (i_dbg_register)
            5'd2:  o_dbg_reg_nibble = c_q[i_dbg_reg_ptr];
            5'd16: o_dbg_reg_nibble = p_q;
            5'd17: if (i_dbg_reg_ptr < 4'd4)
                       o_dbg_reg_nibble = st_q[{i_dbg_reg_ptr[1:0], 2'b00} +: 4];
            5'd18: o_dbg_reg_nibble = hst_q;
            default: o_dbg_reg_nibble = 4'h0;
        endcase
    end

    assign o_program_address = wp_q;
    assign o_program_data    = prog_q[i_program_address];
    assign o_no_read         = (top_q == S_INIT) || i_bus_busy || err_q;
    assign o_error           = err_q;
    assign o_current_pc      = cpc_q;
    assign o_reg_hst         = hst_q;
    assign o_reg_st          = st_q;
    assign o_reg_p           = p_q;
    assign o_alu_reg_dest    = dest_q;
    assign o_alu_reg_src_1   = dest_q;
    assign o_alu_reg_src_2   = 5'd0;
    assign o_alu_imm_value   = imm_q;
    assign o_alu_opcode      = aluop_q;
    assign o_instr_type      = type_q;
    assign o_instr_decoded   = pulse_q;

`ifdef SATURN_CTRL_TRACE_EN
    function automatic string mnem(input logic [3:0] t);
        case (t)
            4'd1:    return "P=n";
            4'd2:    return "LC";
            4'd3:    return "ST=n";
            4'd4:    return "CLRHST";
            default: return "?";
        endcase
    endfunction

    // Simulation-only trace on each decode completion and on entering error.
    always @(posedge i_clk) begin
        if (i_reset_n && i_clk_en && pend_q && i_phases == 4'b0100)
            $display("CTRL %0d: [%0d] %05h %s", i_phase, i_cycle_ctr, cpc_q, mnem(type_q));
        if (i_reset_n && err_d && !err_q)
            $display("CTRL %0d: [%0d] %05h ERROR", i_phase, i_cycle_ctr, cpc_d);
    end
`endif
endmodule

// File: tb/tb_saturn_control_unit.sv
module tb_saturn_control_unit;
    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic i_reset_n = 1'b0, i_clk_en = 1'b0, i_bus_busy = 1'b1;
    logic [3:0] i_phases = 4'b0001, i_nibble = 4'h0, i_dbg_reg_ptr = 4'h0;
    logic [1:0] i_phase = 2'd0;
    logic [31:0] i_cycle_ctr = 32'd0;
    logic [4:0] i_program_address = 5'd0, i_dbg_register = 5'd0;
    logic [4:0] o_program_address, o_program_data, o_alu_reg_dest, o_alu_reg_src_1;
    logic [4:0] o_alu_reg_src_2, o_alu_opcode;
    logic o_no_read, o_error, o_instr_decoded;
    logic [19:0] o_current_pc;
    logic [3:0] o_reg_hst, o_reg_p, o_dbg_reg_nibble, o_alu_imm_value, o_instr_type;
    logic [15:0] o_reg_st;

    saturn_control_unit dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_clk_en(i_clk_en), .i_phases(i_phases),
        .i_phase(i_phase), .i_cycle_ctr(i_cycle_ctr), .i_bus_busy(i_bus_busy),
        .o_program_address(o_program_address), .i_program_address(i_program_address),
        .o_program_data(o_program_data), .o_no_read(o_no_read), .i_nibble(i_nibble),
        .o_error(o_error), .o_current_pc(o_current_pc), .o_reg_hst(o_reg_hst),
        .o_reg_st(o_reg_st), .o_reg_p(o_reg_p), .i_dbg_register(i_dbg_register),
        .i_dbg_reg_ptr(i_dbg_reg_ptr), .o_dbg_reg_nibble(o_dbg_reg_nibble),
        .o_alu_reg_dest(o_alu_reg_dest), .o_alu_reg_src_1(o_alu_reg_src_1),
        .o_alu_reg_src_2(o_alu_reg_src_2), .o_alu_imm_value(o_alu_imm_value),
        .o_alu_opcode(o_alu_opcode), .o_instr_type(o_instr_type),
        .o_instr_decoded(o_instr_decoded)
    );

    always @(posedge i_clk) i_cycle_ctr <= i_cycle_ctr + 32'd1;

    int errors = 0, checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model: instruction assembled from a nibble queue
    logic [3:0]  mq[$];
    logic [3:0]  m_p, m_hst;
    logic [15:0] m_st;
    logic [3:0]  m_c [16];
    logic [19:0] m_pc, m_cpc;
    bit          m_err;

    task automatic model_reset();
        mq.delete();
        m_p = 0; m_hst = 0; m_st = 0; m_pc = 0; m_cpc = 0; m_err = 0;
        for (int i = 0; i < 16; i++) m_c[i] = 0;
    endtask

    task automatic model_nib(input logic [3:0] nib, output bit done);
        done = 0;
        if (m_err) return;
        if (mq.size() == 0) m_cpc = m_pc;
        mq.push_back(nib);
        m_pc = m_pc + 20'd1;
        case (mq[0])
            4'h2: if (mq.size() == 2) begin m_p = mq[1]; done = 1; end
            4'h3: if (mq.size() >= 2 && mq.size() == int'(mq[1]) + 3) begin
                for (int i = 0; i <= int'(mq[1]); i++) m_c[(int'(m_p) + i) % 16] = mq[2 + i];
                done = 1;
            end
            4'h8: if (mq.size() >= 2) begin
                if (!(mq[1] inside {4'h2, 4'h4, 4'h5})) m_err = 1;
                else if (mq.size() == 3) begin
                    if (mq[1] == 4'h4) m_st[mq[2]] = 1'b0;
                    else if (mq[1] == 4'h5) m_st[mq[2]] = 1'b1;
                    else m_hst = m_hst & ~mq[2];
                    done = 1;
                end
            end
            default: m_err = 1;
        endcase
        if (done || m_err) mq.delete();
    endtask

    // ---------------- drivers
    task automatic cyc(input int idx, input logic [3:0] nib, input logic busy, input logic en);
        i_phases = 4'b0001 << idx; i_phase = 2'(idx);
        i_nibble = nib; i_bus_busy = busy; i_clk_en = en;
        @(posedge i_clk); #1;
    endtask

    task automatic send(input logic [3:0] nib);
        bit done;
        model_nib(nib, done);
        cyc(0, 4'h0, 1'b0, 1'b1);
        cyc(1, nib, 1'b0, 1'b1);
        cyc(2, 4'h0, 1'b0, 1'b1);
        chk("decoded_pulse", o_instr_decoded, done);
        cyc(3, 4'h0, 1'b0, 1'b1);
        chk("decoded_clear", o_instr_decoded, 1'b0);
    endtask

    task automatic dbg(input logic [4:0] r, input logic [3:0] ptr, output logic [3:0] v);
        i_clk_en = 1'b0; i_dbg_register = r; i_dbg_reg_ptr = ptr;
        @(negedge i_clk); #1;
        v = o_dbg_reg_nibble;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_reset_n = 1'b0; i_clk_en = 1'b0; i_bus_busy = 1'b1;
        #2;
        chk("rst_wp", o_program_address, 5'd0);
        chk("rst_err", o_error, 1'b0);
        chk("rst_noread", o_no_read, 1'b1);
        chk("rst_p", o_reg_p, 4'd0);
        chk("rst_st", o_reg_st, 16'd0);
        chk("rst_hst", o_reg_hst, 4'd0);
        chk("rst_dec", o_instr_decoded, 1'b0);
        chk("rst_type", o_instr_type, 4'd0);
        chk("rst_op", o_alu_opcode, 5'd0);
        chk("rst_dest", o_alu_reg_dest, 5'd0);
        chk("rst_cpc", o_current_pc, 20'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        model_reset();
    endtask

    task automatic init_fill();
        logic [4:0] exp_e;
        for (int k = 0; k < 6; k++) cyc(k % 4, 4'h0, 1'b1, 1'b1);
        chk("init_wp", o_program_address, 5'd6);
        chk("init_noread_busy", o_no_read, 1'b1);
        for (int k = 0; k < 6; k++) begin
            i_program_address = 5'(k);
            #1;
            exp_e = (k == 0) ? 5'h14 : 5'h00;
            chk($sformatf("init_entry%0d", k), o_program_data, exp_e);
        end
        i_bus_busy = 1'b0; #1;
        chk("noread_idle", o_no_read, 1'b0);
    endtask

    // ---------------- directed table
    typedef struct {
        int          n;
        logic [23:0] nibs;
        logic [3:0]  p;
        logic [15:0] st;
        logic [3:0]  hst, typ, imm;
        logic [4:0]  dest, op;
        logic [19:0] cpc;
        logic [3:0]  didx, dval;
    } vec_t;
    vec_t tbl [8];

    initial begin
        logic [23:0] tmp;
        logic [3:0]  v, nib;
        tbl[0] = '{n:2, nibs:24'h000052, p:4'h5, st:16'h0, hst:0, typ:1, imm:4'h5, dest:16, op:1, cpc:20'h0,  didx:1,  dval:4'h0};
        tbl[1] = '{n:2, nibs:24'h000002, p:4'h0, st:16'h0, hst:0, typ:1, imm:4'h0, dest:16, op:1, cpc:20'h2,  didx:1,  dval:4'h0};
        tbl[2] = '{n:4, nibs:24'h00BA13, p:4'h0, st:16'h0, hst:0, typ:2, imm:4'hB, dest:2,  op:1, cpc:20'h4,  didx:0,  dval:4'hA};
        tbl[3] = '{n:2, nibs:24'h0000F2, p:4'hF, st:16'h0, hst:0, typ:1, imm:4'hF, dest:16, op:1, cpc:20'h8,  didx:1,  dval:4'hB};
        tbl[4] = '{n:4, nibs:24'h008713, p:4'hF, st:16'h0, hst:0, typ:2, imm:4'h8, dest:2,  op:1, cpc:20'hA,  didx:15, dval:4'h7};
        tbl[5] = '{n:3, nibs:24'h000358, p:4'hF, st:16'h8, hst:0, typ:3, imm:4'h3, dest:17, op:3, cpc:20'hE,  didx:0,  dval:4'h8};
        tbl[6] = '{n:3, nibs:24'h000348, p:4'hF, st:16'h0, hst:0, typ:3, imm:4'h3, dest:17, op:2, cpc:20'h11, didx:1,  dval:4'hB};
        tbl[7] = '{n:3, nibs:24'h000F28, p:4'hF, st:16'h0, hst:0, typ:4, imm:4'hF, dest:18, op:2, cpc:20'h14, didx:2,  dval:4'h0};

        do_reset();
        init_fill();

        for (int r = 0; r < 8; r++) begin
            tmp = tbl[r].nibs;
            for (int k = 0; k < tbl[r].n; k++) begin
                nib = tmp[4*k +: 4];
                send(nib);
            end
            chk($sformatf("t%0d_p", r), o_reg_p, tbl[r].p);
            chk($sformatf("t%0d_st", r), o_reg_st, tbl[r].st);
            chk($sformatf("t%0d_hst", r), o_reg_hst, tbl[r].hst);
            chk($sformatf("t%0d_type", r), o_instr_type, tbl[r].typ);
            chk($sformatf("t%0d_dest", r), o_alu_reg_dest, tbl[r].dest);
            chk($sformatf("t%0d_src1", r), o_alu_reg_src_1, tbl[r].dest);
            chk($sformatf("t%0d_src2", r), o_alu_reg_src_2, 5'd0);
            chk($sformatf("t%0d_op", r), o_alu_opcode, tbl[r].op);
            if (tbl[r].typ <= 4'd2) chk($sformatf("t%0d_imm", r), o_alu_imm_value, tbl[r].imm);
            chk($sformatf("t%0d_cpc", r), o_current_pc, tbl[r].cpc);
            dbg(5'd2, tbl[r].didx, v);
            chk($sformatf("t%0d_dbgC", r), v, tbl[r].dval);
        end
        dbg(5'd16, 4'd0, v);  chk("dbg_P", v, 4'hF);
        dbg(5'd0, 4'd3, v);   chk("dbg_A", v, 4'h0);
        dbg(5'd5, 4'd0, v);   chk("dbg_bad", v, 4'h0);

        // ST debug view: nibble 0 after setting ST[3], out-of-range ptr reads 0
        send(4'h8); send(4'h5); send(4'h3);
        send(4'h8); send(4'h5); send(4'hF);
        dbg(5'd17, 4'd0, v);  chk("dbg_st0", v, 4'h8);
        dbg(5'd17, 4'd3, v);  chk("dbg_st3", v, 4'h8);
        dbg(5'd17, 4'd4, v);  chk("dbg_st_oob", v, 4'h0);
        chk("st_full", o_reg_st, 16'h8008);

        // randomized instruction stream with bus/enable stalls vs model
        for (int it = 0; it < 150; it++) begin
            logic [3:0] ins[$];
            int kind, n;
            ins.delete();
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin ins.push_back(4'h2); ins.push_back(4'($urandom)); end
                1: begin
                    n = $urandom_range(0, 5);
                    ins.push_back(4'h3); ins.push_back(4'(n));
                    for (int k = 0; k <= n; k++) ins.push_back(4'($urandom));
                end
                2: begin
                    ins.push_back(4'h8); ins.push_back($urandom_range(0, 1) ? 4'h5 : 4'h4);
                    ins.push_back(4'($urandom));
                end
                default: begin ins.push_back(4'h8); ins.push_back(4'h2); ins.push_back(4'($urandom)); end
            endcase
            foreach (ins[k]) begin
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 1) cyc(1, 4'($urandom), 1'b1, 1'b1);
                    else cyc(1, 4'($urandom), 1'b0, 1'b0);
                    chk("stall_p", o_reg_p, m_p);
                    chk("stall_cpc", o_current_pc, m_cpc);
                end
                send(ins[k]);
            end
            chk("rnd_p", o_reg_p, m_p);
            chk("rnd_st", o_reg_st, m_st);
            chk("rnd_hst", o_reg_hst, m_hst);
            chk("rnd_cpc", o_current_pc, m_cpc);
            n = $urandom_range(0, 15);
            dbg(5'd2, 4'(n), v);
            chk("rnd_c", v, m_c[n]);
        end
        for (int i = 0; i < 16; i++) begin
            dbg(5'd2, 4'(i), v);
            chk($sformatf("rnd_cfinal%0d", i), v, m_c[i]);
        end

        // unsupported opcode: sticky error, later nibbles ignored
        send(4'h1);
        chk("err_set", o_error, 1'b1);
        chk("err_noread", o_no_read, 1'b1);
        send(4'h2); send(4'h7);
        chk("err_frozen_p", o_reg_p, m_p);
        chk("err_sticky", o_error, 1'b1);
        do_reset();
        chk("err_cleared", o_error, 1'b0);
        init_fill();

        // reset in the middle of an LC
        send(4'h3); send(4'h3); send(4'hA);
        dbg(5'd2, 4'd0, v);   chk("midlc_c0", v, 4'hA);
        do_reset();
        for (int i = 0; i < 16; i++) begin
            dbg(5'd2, 4'(i), v);
            chk($sformatf("midlc_clr%0d", i), v, 4'h0);
        end
        for (int k = 0; k < 3; k++) cyc(k, 4'h0, 1'b1, 1'b1);
        chk("reinit_wp3", o_program_address, 5'd3);
        cyc(0, 4'h0, 1'b1, 1'b0);
        chk("reinit_hold", o_program_address, 5'd3);
        for (int k = 0; k < 3; k++) cyc(k, 4'h0, 1'b1, 1'b1);
        chk("reinit_wp6", o_program_address, 5'd6);
        send(4'h2); send(4'h9);
        chk("after_reinit_p", o_reg_p, 4'h9);
        chk("after_reinit_cpc", o_current_pc, 20'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/saturn_control_unit.md
Name: saturn_control_unit

Overview:
Instruction-fetch/decode core of the Saturn CPU, driven by the bus controller's 4-phase sequencer.
- After reset, fills a 32-entry bus program list with the PC-load sequence for the bus controller to drain.
- Consumes instruction nibbles, decodes a minimal Saturn subset and updates P/ST/HST/C.
- Publishes ALU-field and debugger views of its state.

Parameters:
- PROG_DEPTH, 32, bus program list entries (address width 5; wraps mod 32).
- RESET_PC, 20'h00000, PC loaded at reset and sent in the init program.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_clk_en  in  1  state advances only when 1 (0 during debug cycles).
- i_phases  in  4  one-hot phase: 0001, 0010, 0100, 1000.
- i_phase  in  2  phase index 0..3 (trace only).
- i_cycle_ctr  in  32  cycle counter (trace only).
- i_bus_busy  in  1  bus controller still draining the program list.
- o_program_address  out  5  write pointer (next free entry) of the program list.
- i_program_address  in  5  bus controller read pointer.
- o_program_data  out  5  entry at i_program_address, combinational; bit4=1 CMD, 0 DATA; [3:0] nibble.
- o_no_read  out  1  1 = bus must not perform a read.
- i_nibble  in  4  nibble read from the bus.
- o_error  out  1  sticky unsupported-opcode flag.
- o_current_pc  out  20  address of first nibble of current instruction.
- o_reg_hst  out  4  HST register.
- o_reg_st  out  16  ST register.
- o_reg_p  out  4  P register.
- i_dbg_register  in  5  debug register select.
- i_dbg_reg_ptr  in  4  debug nibble index.
- o_dbg_reg_nibble  out  4  selected nibble, combinational.
- o_alu_reg_dest, o_alu_reg_src_1, o_alu_reg_src_2  out  5 each  register codes.
- o_alu_imm_value  out  4  immediate nibble.
- o_alu_opcode  out  5  ALU op.
- o_instr_type  out  4  decoded instruction class.
- o_instr_decoded  out  1  one-enabled-cycle pulse at decode completion.

Behaviour:
- Reset (async): state INIT, write pointer 0, PC=RESET_PC, P=0, ST=0, HST=0, A–D=0, o_error=0, o_no_read=1, o_instr_decoded=0. All ALU and type outputs are 0.
- INIT: one entry is written per enabled clock, any phase:
  - [0] = CMD 4 (LOAD_PC).
  - [1..5] = DATA RESET_PC nibbles, LSN first.
  - Pointer ends at 6, then state goes to RUN.
- RUN: o_no_read = i_bus_busy | o_error.
- Nibble accept: in phase 0010 with i_clk_en=1, !i_bus_busy and !o_error, i_nibble enters the decoder and PC increments by 1 (20-bit wrap).
- Decoder states: IDLE, OP2, LC_DATA, ST_N, HST_N.
  - "2n": P=n; type 1, dest 16, imm n, opcode 1.
  - "3n d0..dn": loads n+1 nibbles into C starting at nibble P, index wrapping mod 16; type 2, dest 2. Each nibble drives imm=d and opcode 1. Decode completes at the last nibble.
  - "84n": ST[n]=0; type 3, dest 17, opcode 2.
  - "85n": ST[n]=1; type 3, dest 17, opcode 3.
  - "82n": HST &= ~n; type 4, dest 18, opcode 2.
  - Any other first/second nibble: o_error=1 (sticky until reset), decoder frozen.
- o_instr_decoded rises at the phase 0100 after the final nibble is accepted. It clears on the next enabled clock.
- o_current_pc latches PC at the first nibble of each instruction.
- src_1 = dest; src_2 = 0.
- Debug register codes: 0 A, 1 B, 2 C, 3 D, 16 P, 17 ST, 18 HST. Other codes return 0. For ST, the index selects a nibble of the 16 bits (ptr>3 returns 0).
- i_clk_en=0: no state change, outputs held.

Optional Feature:
- SATURN_CTRL_TRACE_EN defined: prints "CTRL <phase>: [<cycle>] <pc> <mnemonic>" on each decode and on error. This is simulation only.
- Undefined: no prints. Logic is identical either way.

Test Plan:
- Reset, i_clk_en=1 for 6 clocks, read program entries 0..5 via i_program_address -> 5'h14, 5'h00 ×5; o_program_address=6; o_no_read=1 while i_bus_busy=1.
- Bus idle, feed 2,5 in phase 0010 -> o_reg_p=5, one o_instr_decoded pulse, type 1, o_current_pc=0, PC=2.
- P=0, feed 3,1,A,B -> dbg register 2: ptr0=A, ptr1=B; type 2. P=F, feed 3,1,7,8 -> C[15]=7, C[0]=8 (wrap).
- Feed 8,5,3 then 8,4,3 -> o_reg_st 0x0008 then 0x0000. With HST=0, feed 8,2,F -> HST stays 0.
- Feed nibble 1 -> o_error=1, o_no_read=1, later nibbles ignored. Pulling i_reset_n low clears o_error.
- Hold i_bus_busy=1 or i_clk_en=0 during phase 0010 -> PC and registers unchanged. Reset mid-LC -> C cleared, INIT restarts.
